// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// Forward-select encodings, FSM state type and the register-match helper.
package pipe_ctrl_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } ctrl_state_t;

  // $0 is hardwired to zero, so a producer writing it never feeds a consumer.
  function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
    return (src != 5'd0) && (dst == src);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: stage register ids/controls in,
// forward selects, stall/flush enables and status out.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
) ();
  logic [4:0]       rs_D, rt_D, rs_E, rt_E;
  logic [4:0]       WriteReg_E, WriteReg_M, WriteReg_WB;
  logic             RegWrite_E, RegWrite_M, RegWrite_WB;
  logic             MemtoReg_E, MemtoReg_M;
  logic             Branch_D, PCSrc_D, Jump_D;
  logic             mem_req_M, mem_ready;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             ForwardAD, ForwardBD;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushW;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output rs_D, rt_D, rs_E, rt_E, WriteReg_E, WriteReg_M, WriteReg_WB,
           RegWrite_E, RegWrite_M, RegWrite_WB, MemtoReg_E, MemtoReg_M,
           Branch_D, PCSrc_D, Jump_D, mem_req_M, mem_ready,
    input  ForwardAE, ForwardBE, ForwardAD, ForwardBD,
           StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           mem_err, stall_cycles
  );

  modport slave (
    input  rs_D, rt_D, rs_E, rt_E, WriteReg_E, WriteReg_M, WriteReg_WB,
           RegWrite_E, RegWrite_M, RegWrite_WB, MemtoReg_E, MemtoReg_M,
           Branch_D, PCSrc_D, Jump_D, mem_req_M, mem_ready,
    output ForwardAE, ForwardBE, ForwardAD, ForwardBD,
           StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           mem_err, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_fwd.sv
// Purely combinational hazard detection: EX/D operand forwarding selects plus
// load-use and branch-compare stall requests.
module hazard_fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [4:0] rs_E,
  input  logic [4:0] rt_E,
  input  logic [4:0] WriteReg_E,
  input  logic [4:0] WriteReg_M,
  input  logic [4:0] WriteReg_WB,
  input  logic       RegWrite_E,
  input  logic       RegWrite_M,
  input  logic       RegWrite_WB,
  input  logic       MemtoReg_E,
  input  logic       MemtoReg_M,
  input  logic       Branch_D,
  output logic [1:0] fwd_ae,
  output logic [1:0] fwd_be,
  output logic       fwd_ad,
  output logic       fwd_bd,
  output logic       lwstall,
  output logic       brstall
);

  logic e_hits_d_s;
  logic m_hits_d_s;

  // EX operand selects; the younger MEM result wins over WB on a double match.
  always_comb begin
    fwd_ae = FWD_RF;
    fwd_be = FWD_RF;
    if (RegWrite_M && reg_match(WriteReg_M, rs_E)) begin
      fwd_ae = FWD_MEM;
    end else if (RegWrite_WB && reg_match(WriteReg_WB, rs_E)) begin
      fwd_ae = FWD_WB;
    end else begin
      fwd_ae = FWD_RF;
    end
    if (RegWrite_M && reg_match(WriteReg_M, rt_E)) begin
      fwd_be = FWD_MEM;
    end else if (RegWrite_WB && reg_match(WriteReg_WB, rt_E)) begin
      fwd_be = FWD_WB;
    end else begin
      fwd_be = FWD_RF;
    end
  end

  // Decode compare forwarding and the two stall requests.
  always_comb begin
    fwd_ad     = RegWrite_M && reg_match(WriteReg_M, rs_D);
    fwd_bd     = RegWrite_M && reg_match(WriteReg_M, rt_D);
    e_hits_d_s = reg_match(WriteReg_E, rs_D) || reg_match(WriteReg_E, rt_D);
    m_hits_d_s = reg_match(WriteReg_M, rs_D) || reg_match(WriteReg_M, rt_D);
    lwstall    = MemtoReg_E && (rt_E != 5'd0) && ((rt_E == rs_D) || (rt_E == rt_D));
    brstall    = Branch_D && ((RegWrite_E && e_hits_d_s) || (MemtoReg_M && m_hits_d_s));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: memory-wait FSM with timeout watchdog, stall/flush priority
// mux over the hazard unit, sticky error flag and stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  pipe_hazard_ctrl_if.slave bus
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  ctrl_state_t      state_r, state_nxt_s;
  logic [7:0]       wait_cnt_r;
  logic             mem_err_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic             timeout_s, memwait_s;
  logic [1:0]       fwd_ae_s, fwd_be_s;
  logic             fwd_ad_s, fwd_bd_s, lwstall_s, brstall_s;
  logic             stall_f_s, stall_d_s, stall_e_s, stall_m_s;
  logic             flush_d_s, flush_e_s, flush_w_s;

  hazard_fwd_unit u_hazard_fwd (
    .rs_D        (bus.rs_D),
    .rt_D        (bus.rt_D),
    .rs_E        (bus.rs_E),
    .rt_E        (bus.rt_E),
    .WriteReg_E  (bus.WriteReg_E),
    .WriteReg_M  (bus.WriteReg_M),
    .WriteReg_WB (bus.WriteReg_WB),
    .RegWrite_E  (bus.RegWrite_E),
    .RegWrite_M  (bus.RegWrite_M),
    .RegWrite_WB (bus.RegWrite_WB),
    .MemtoReg_E  (bus.MemtoReg_E),
    .MemtoReg_M  (bus.MemtoReg_M),
    .Branch_D    (bus.Branch_D),
    .fwd_ae      (fwd_ae_s),
    .fwd_be      (fwd_be_s),
    .fwd_ad      (fwd_ad_s),
    .fwd_bd      (fwd_bd_s),
    .lwstall     (lwstall_s),
    .brstall     (brstall_s)
  );

  // Next state and freeze request; the timeout cycle itself releases the freeze.
  always_comb begin
    state_nxt_s = state_r;
    timeout_s   = 1'b0;
    case (state_r)
      RUN: begin
        if (bus.mem_req_M && !bus.mem_ready) begin
          state_nxt_s = MEM_WAIT;
        end else begin
          state_nxt_s = RUN;
        end
      end
      MEM_WAIT: begin
        if (bus.mem_ready) begin
          state_nxt_s = RUN;
        end else if (wait_cnt_r == TO_LAST) begin
          state_nxt_s = RUN;
          timeout_s   = 1'b1;
        end else begin
          state_nxt_s = MEM_WAIT;
        end
      end
      default: begin
        state_nxt_s = RUN;
      end
    endcase
    memwait_s = !bus.mem_ready && !timeout_s &&
                (((state_r == RUN) && bus.mem_req_M) || (state_r == MEM_WAIT));
  end

  // Stall/flush priority mux: reset, then memory freeze, then data hazards.
  always_comb begin
    stall_f_s = 1'b0;
    stall_d_s = 1'b0;
    stall_e_s = 1'b0;
    stall_m_s = 1'b0;
    flush_d_s = 1'b0;
    flush_e_s = 1'b0;
    flush_w_s = 1'b0;
    if (!reset) begin
      stall_f_s = 1'b0;
    end else if (memwait_s) begin
      stall_f_s = 1'b1;
      stall_d_s = 1'b1;
      stall_e_s = 1'b1;
      stall_m_s = 1'b1;
      flush_w_s = 1'b1;
    end else if (lwstall_s || brstall_s) begin
      stall_f_s = 1'b1;
      stall_d_s = 1'b1;
      flush_e_s = 1'b1;
    end else begin
      flush_d_s = bus.PCSrc_D || bus.Jump_D;
    end
  end

  assign bus.ForwardAE    = reset ? fwd_ae_s : FWD_RF;
  assign bus.ForwardBE    = reset ? fwd_be_s : FWD_RF;
  assign bus.ForwardAD    = reset && fwd_ad_s;
  assign bus.ForwardBD    = reset && fwd_bd_s;
  assign bus.StallF       = stall_f_s;
  assign bus.StallD       = stall_d_s;
  assign bus.StallE       = stall_e_s;
  assign bus.StallM       = stall_m_s;
  assign bus.FlushD       = flush_d_s;
  assign bus.FlushE       = flush_e_s;
  assign bus.FlushW       = flush_w_s;
  assign bus.mem_err      = mem_err_r;
  assign bus.stall_cycles = stall_cnt_r;

  // State, wait counter, sticky error and saturating stall counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= RUN;
      wait_cnt_r  <= 8'd0;
      mem_err_r   <= 1'b0;
      stall_cnt_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == MEM_WAIT) && (state_nxt_s == MEM_WAIT)) begin
        wait_cnt_r <= wait_cnt_r + 8'd1;
      end else begin
        wait_cnt_r <= 8'd0;
      end
      if (timeout_s) begin
        mem_err_r <= 1'b1;
      end
      if (stall_f_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: expected output vectors are queued
// as each cycle's stimulus is driven and compared when the outputs settle.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic [1:0] fae;
    logic [1:0] fbe;
    logic       fad;
    logic       fbd;
    logic [3:0] stl;   // {F,D,E,M}
    logic [2:0] fl;    // {D,E,W}
    logic       err;
  } exp_t;

  localparam logic [3:0] S_NONE = 4'b0000;
  localparam logic [3:0] S_HAZ  = 4'b1100;
  localparam logic [3:0] S_ALL  = 4'b1111;
  localparam logic [2:0] F_NONE = 3'b000;
  localparam logic [2:0] F_D    = 3'b100;
  localparam logic [2:0] F_E    = 3'b010;
  localparam logic [2:0] F_W    = 3'b001;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  pipe_hazard_ctrl_if #(.CNT_W(32)) bus ();

  pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic exp_t ex(input logic [1:0] fae, input logic [1:0] fbe,
                              input logic fad, input logic fbd,
                              input logic [3:0] stl, input logic [2:0] fl, input logic err);
    return {fae, fbe, fad, fbd, stl, fl, err};
  endfunction

  function automatic exp_t observed();
    return {bus.ForwardAE, bus.ForwardBE, bus.ForwardAD, bus.ForwardBD,
            bus.StallF, bus.StallD, bus.StallE, bus.StallM,
            bus.FlushD, bus.FlushE, bus.FlushW, bus.mem_err};
  endfunction

  task automatic clr();
    bus.rs_D = 5'd0;  bus.rt_D = 5'd0;  bus.rs_E = 5'd0;  bus.rt_E = 5'd0;
    bus.WriteReg_E = 5'd0; bus.WriteReg_M = 5'd0; bus.WriteReg_WB = 5'd0;
    bus.RegWrite_E = 1'b0; bus.RegWrite_M = 1'b0; bus.RegWrite_WB = 1'b0;
    bus.MemtoReg_E = 1'b0; bus.MemtoReg_M = 1'b0;
    bus.Branch_D = 1'b0; bus.PCSrc_D = 1'b0; bus.Jump_D = 1'b0;
    bus.mem_req_M = 1'b0; bus.mem_ready = 1'b0;
  endtask

  // Inputs are already driven; queue the expectation, compare mid-cycle, step to next cycle.
  task automatic cyc(input string tag, input exp_t e);
    exp_t want;
    exp_q.push_back(e);
    @(negedge clk);
    want = exp_q.pop_front();
    check_eq(tag, 32'(observed()), 32'(want));
    @(posedge clk);
    #1;
  endtask

  task automatic load_use();
    bus.MemtoReg_E = 1'b1; bus.rt_E = 5'd9; bus.rs_D = 5'd9;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    clk = 1'b0; reset = 1'b0; checks = 0; errors = 0;
    clr();
    repeat (2) @(posedge clk);
    #1;
    // Reset masks everything even with live hazards and a memory stall pending.
    bus.RegWrite_M = 1'b1; bus.WriteReg_M = 5'd8; bus.rs_E = 5'd8;
    load_use(); bus.mem_req_M = 1'b1;
    cyc("rst_force", ex(2'b00, 2'b00, 1'b0, 1'b0, S_NONE, F_NONE, 1'b0));
    check_eq("rst_cnt", bus.stall_cycles, 32'd0);
    check_eq("rst_err", 32'(bus.mem_err), 32'd0);
    reset = 1'b1; clr();

    bus.RegWrite_M = 1'b1; bus.WriteReg_M = 5'd8; bus.rs_E = 5'd8;
    bus.RegWrite_WB = 1'b1; bus.WriteReg_WB = 5'd8;
    cyc("fwd_mem_pri", ex(2'b10, 2'b00, 1'b0, 1'b0, S_NONE, F_NONE, 1'b0));
    bus.RegWrite_M = 1'b0; bus.rt_E = 5'd8;
    cyc("fwd_wb", ex(2'b01, 2'b01, 1'b0, 1'b0, S_NONE, F_NONE, 1'b0));
    clr();
    bus.RegWrite_M = 1'b1; bus.RegWrite_WB = 1'b1;
    cyc("fwd_r0", ex(2'b00, 2'b00, 1'b0, 1'b0, S_NONE, F_NONE, 1'b0));
    bus.WriteReg_M = 5'd3; bus.WriteReg_WB = 5'd3; bus.rt_E = 5'd3;
    bus.rs_D = 5'd3; bus.rt_D = 5'd3;
    cyc("fwd_b_d", ex(2'b00, 2'b10, 1'b1, 1'b1, S_NONE, F_NONE, 1'b0));

    clr(); load_use(); bus.PCSrc_D = 1'b1;
    cyc("lwstall", ex(2'b00, 2'b00, 1'b0, 1'b0, S_HAZ, F_E, 1'b0));
    clr(); bus.MemtoReg_E = 1'b1;
    cyc("lw_r0", ex(2'b00, 2'b00, 1'b0, 1'b0, S_NONE, F_NONE, 1'b0));

    clr(); bus.Branch_D = 1'b1; bus.RegWrite_E = 1'b1; bus.WriteReg_E = 5'd5; bus.rt_D = 5'd5;
    cyc("br_ex", ex(2'b00, 2'b00, 1'b0, 1'b0, S_HAZ, F_E, 1'b0));
    bus.RegWrite_E = 1'b0; bus.RegWrite_M = 1'b1; bus.WriteReg_M = 5'd5; bus.PCSrc_D = 1'b1;
    cyc("br_fwd", ex(2'b00, 2'b00, 1'b0, 1'b1, S_NONE, F_D, 1'b0));
    bus.MemtoReg_M = 1'b1;
    cyc("br_load", ex(2'b00, 2'b00, 1'b0, 1'b1, S_HAZ, F_E, 1'b0));
    clr(); bus.Jump_D = 1'b1;
    cyc("jump", ex(2'b00, 2'b00, 1'b0, 1'b0, S_NONE, F_D, 1'b0));
    check_eq("cnt_haz", bus.stall_cycles, 32'd3);

    // Slow access with a load-use hiding behind it: freeze masks it until release.
    clr(); load_use(); bus.PCSrc_D = 1'b1; bus.mem_req_M = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc("memwait", ex(2'b00, 2'b00, 1'b0, 1'b0, S_ALL, F_W, 1'b0));
    end
    bus.mem_ready = 1'b1;
    cyc("mem_release", ex(2'b00, 2'b00, 1'b0, 1'b0, S_HAZ, F_E, 1'b0));
    clr();
    cyc("mem_run", ex(2'b00, 2'b00, 1'b0, 1'b0, S_NONE, F_NONE, 1'b0));
    check_eq("cnt_mem", bus.stall_cycles, 32'd7);

    // Watchdog: 1 RUN cycle + 3 waits frozen, 4th wait aborts and advances.
    bus.mem_req_M = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc("to_wait", ex(2'b00, 2'b00, 1'b0, 1'b0, S_ALL, F_W, 1'b0));
    end
    cyc("to_abort", ex(2'b00, 2'b00, 1'b0, 1'b0, S_NONE, F_NONE, 1'b0));
    clr();
    for (int i = 0; i < 2; i++) begin
      cyc("err_sticky", ex(2'b00, 2'b00, 1'b0, 1'b0, S_NONE, F_NONE, 1'b1));
    end
    check_eq("cnt_to", bus.stall_cycles, 32'd11);

    // Reset in the middle of a wait with a concurrent load-use.
    bus.mem_req_M = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc("pre_rst_wait", ex(2'b00, 2'b00, 1'b0, 1'b0, S_ALL, F_W, 1'b1));
    end
    load_use(); reset = 1'b0;
    cyc("mid_rst", ex(2'b00, 2'b00, 1'b0, 1'b0, S_NONE, F_NONE, 1'b1));
    check_eq("mid_rst_cnt", bus.stall_cycles, 32'd0);
    reset = 1'b1; bus.mem_req_M = 1'b0;
    cyc("post_rst_run", ex(2'b00, 2'b00, 1'b0, 1'b0, S_HAZ, F_E, 1'b0));
    check_eq("post_rst_cnt", bus.stall_cycles, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
